// File: rtl/multiport_dynamic_ram_pkg.sv
// rtl/multiport_dynamic_ram_pkg.sv - shared widths and lane slicing helper for the multiport RAM
//
// Purpose: default word/address widths, default depth and port count, and a
// helper that gives the LSB position of lane N in a packed multi-port bus.
// Callers use lane_lsb() to pack and unpack buses with the same layout as the RAM.
package multiport_dynamic_ram_pkg;

  localparam int MEM_WIDTH  = 12;
  localparam int ADDR_WIDTH = 12;
  localparam int MEM_SIZE   = 4096;
  localparam int PORT_COUNT = 2;

  // Lane N of a packed bus occupies bits [lane_lsb(N, w) +: w].
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/multiport_dynamic_ram.sv
// rtl/multiport_dynamic_ram.sv - parameterised multi-port synchronous RAM, read-first, sync reset
//
// Purpose: shared data/instruction memory. Every port reads every cycle and
// may write every cycle; read data is registered (1-cycle latency).
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-low reset; clears memory and dataout
//   address    packed port addresses, lane i = [i*addr_width +: addr_width]
//   datain     packed write data,     lane i = [i*mem_width +: mem_width]
//   mem_write  per-port write enable, bit i = port i
//   dataout    packed registered read data, lane i = [i*mem_width +: mem_width]
module multiport_dynamic_ram
  import multiport_dynamic_ram_pkg::*;
#(
  parameter int mem_size   = MEM_SIZE,
  parameter int mem_width  = MEM_WIDTH,
  parameter int addr_width = ADDR_WIDTH,
  parameter int port_count = PORT_COUNT
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [addr_width*port_count-1:0] address,
  input  logic [mem_width*port_count-1:0]  datain,
  input  logic [port_count-1:0]            mem_write,
  output logic [mem_width*port_count-1:0]  dataout
);

  logic [mem_width-1:0]  mem       [mem_size];
  logic [addr_width-1:0] addr_lane [port_count];
  logic [mem_width-1:0]  din_lane  [port_count];
  logic [port_count-1:0] addr_ok;

  for (genvar p = 0; p < port_count; p++) begin : g_lane
    assign addr_lane[p] = address[lane_lsb(p, addr_width) +: addr_width];
    assign din_lane[p]  = datain[lane_lsb(p, mem_width) +: mem_width];
    // When the array spans the whole address space every address is legal;
    // avoiding the compare there keeps an always-true comparison out of the netlist.
    if (mem_size >= (2 ** addr_width)) begin : g_full
      assign addr_ok[p] = 1'b1;
    end else begin : g_partial
      assign addr_ok[p] = ({1'b0, addr_lane[p]} < (addr_width + 1)'(mem_size));
    end
  end

  // Reads use the pre-edge array contents (non-blocking), giving read-first
  // behaviour. Writes are applied in ascending port order so the highest-index
  // port wins an address collision.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < mem_size; i++) begin
        mem[i] <= '0;
      end
      dataout <= '0;
    end else begin
      for (int p = 0; p < port_count; p++) begin
        dataout[p*mem_width +: mem_width] <= addr_ok[p] ? mem[addr_lane[p]] : '0;
      end
      for (int p = 0; p < port_count; p++) begin
        if (mem_write[p] && addr_ok[p]) begin
          mem[addr_lane[p]] <= din_lane[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_multiport_dynamic_ram.sv
// tb/tb_multiport_dynamic_ram.sv - directed self-checking bench for multiport_dynamic_ram
module tb_multiport_dynamic_ram;

  logic        clk;
  logic        reset;
  logic [23:0] address;
  logic [23:0] datain;
  logic [1:0]  mem_write;
  logic [23:0] dataout;

  int total;
  int bad;

  multiport_dynamic_ram dut (
    .clk       (clk),
    .reset     (reset),
    .address   (address),
    .datain    (datain),
    .mem_write (mem_write),
    .dataout   (dataout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [23:0] a, input logic [23:0] d, input logic [1:0] we);
    address   = a;
    datain    = d;
    mem_write = we;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(24'h000_000, 24'h000_000, 2'b00);
    step();
    total++;
    if (dataout !== 24'h000_000) begin
      $display("FAIL reset_dataout got=%h want=%h", dataout, 24'h000_000);
      bad++;
    end
    reset = 1'b1;
  endtask

  task automatic test_basic_write();
    drive(24'h000_001, 24'h005_FF9, 2'b01);
    step();
    drive(24'h000_001, 24'h000_000, 2'b00);
    step();
    total++;
    if (dataout !== 24'h000_FF9) begin
      $display("FAIL basic_readback got=%h want=%h", dataout, 24'h000_FF9);
      bad++;
    end
    // Garbage data with writes disabled must not change memory.
    drive(24'h001_000, 24'hABC_DEF, 2'b00);
    step();
    total++;
    if (dataout !== 24'hFF9_000) begin
      $display("FAIL write_disabled_read got=%h want=%h", dataout, 24'hFF9_000);
      bad++;
    end
    drive(24'h001_000, 24'h000_000, 2'b00);
    step();
    total++;
    if (dataout !== 24'hFF9_000) begin
      $display("FAIL write_disabled_unchanged got=%h want=%h", dataout, 24'hFF9_000);
      bad++;
    end
  endtask

  task automatic test_dual_write();
    drive(24'h004_008, 24'h004_008, 2'b11);
    step();
    drive(24'h008_004, 24'h000_000, 2'b00);
    step();
    total++;
    if (dataout !== 24'h008_004) begin
      $display("FAIL dual_write_readback got=%h want=%h", dataout, 24'h008_004);
      bad++;
    end
  endtask

  task automatic test_read_first();
    drive(24'h005_005, 24'hAAA_555, 2'b11);
    step();
    total++;
    if (dataout !== 24'h000_000) begin
      $display("FAIL read_first_same_addr got=%h want=%h", dataout, 24'h000_000);
      bad++;
    end
    drive(24'h005_005, 24'h000_000, 2'b00);
    step();
    total++;
    if (dataout !== 24'hAAA_AAA) begin
      $display("FAIL collision_port1_wins got=%h want=%h", dataout, 24'hAAA_AAA);
      bad++;
    end
    // Port 0 writes address 1 while both ports read it: old value returned.
    drive(24'h001_001, 24'h000_123, 2'b01);
    step();
    total++;
    if (dataout !== 24'hFF9_FF9) begin
      $display("FAIL read_first_cross_port got=%h want=%h", dataout, 24'hFF9_FF9);
      bad++;
    end
    drive(24'h001_001, 24'h000_000, 2'b00);
    step();
    total++;
    if (dataout !== 24'h123_123) begin
      $display("FAIL cross_port_new_value got=%h want=%h", dataout, 24'h123_123);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    // Cycle A: port0 writes 0x010, port1 reads 0x010 (old 0).
    drive(24'h010_010, 24'h000_111, 2'b01);
    step();
    total++;
    if (dataout !== 24'h000_000) begin
      $display("FAIL b2b_first got=%h want=%h", dataout, 24'h000_000);
      bad++;
    end
    // Cycle B: port0 writes 0x011, port1 reads 0x010 written last cycle.
    drive(24'h010_011, 24'h000_222, 2'b01);
    step();
    total++;
    if (dataout !== 24'h111_000) begin
      $display("FAIL b2b_second got=%h want=%h", dataout, 24'h111_000);
      bad++;
    end
    drive(24'h011_010, 24'h000_000, 2'b00);
    step();
    total++;
    if (dataout !== 24'h222_111) begin
      $display("FAIL b2b_readback got=%h want=%h", dataout, 24'h222_111);
      bad++;
    end
  endtask

  task automatic test_reset_mid();
    drive(24'h009_009, 24'h777_777, 2'b11);
    reset = 1'b0;
    step();
    total++;
    if (dataout !== 24'h000_000) begin
      $display("FAIL reset_mid_dataout got=%h want=%h", dataout, 24'h000_000);
      bad++;
    end
    reset = 1'b1;
    drive(24'h001_004, 24'h000_000, 2'b00);
    step();
    total++;
    if (dataout !== 24'h000_000) begin
      $display("FAIL reset_mid_cleared_1_4 got=%h want=%h", dataout, 24'h000_000);
      bad++;
    end
    drive(24'h008_009, 24'h000_000, 2'b00);
    step();
    total++;
    if (dataout !== 24'h000_000) begin
      $display("FAIL reset_mid_cleared_8_9 got=%h want=%h", dataout, 24'h000_000);
      bad++;
    end
    drive(24'h005_010, 24'h000_000, 2'b00);
    step();
    total++;
    if (dataout !== 24'h000_000) begin
      $display("FAIL reset_mid_cleared_5_10 got=%h want=%h", dataout, 24'h000_000);
      bad++;
    end
  endtask

  task automatic test_unwritten();
    drive(24'h000_007, 24'h000_000, 2'b00);
    step();
    total++;
    if (dataout !== 24'h000_000) begin
      $display("FAIL unwritten_addr got=%h want=%h", dataout, 24'h000_000);
      bad++;
    end
    // Write after reset still works, and the neighbouring word stays 0.
    drive(24'hFFF_000, 24'hBEE_000, 2'b10);
    step();
    drive(24'hFFF_FFE, 24'h000_000, 2'b00);
    step();
    total++;
    if (dataout !== 24'hBEE_000) begin
      $display("FAIL top_addr_write got=%h want=%h", dataout, 24'hBEE_000);
      bad++;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(24'h000_000, 24'h000_000, 2'b00);
    #2;
    test_reset();
    test_basic_write();
    test_dual_write();
    test_read_first();
    test_back_to_back();
    test_reset_mid();
    test_unwritten();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
